// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with req/ack data-memory handshake and MEM/WB register
module mem_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic        MEMR_i,
  input  logic        MEMW_i,
  input  logic [31:0] ALUout_i,
  input  logic [31:0] RS2_i,
  input  logic [4:0]  RDaddr_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [1:0]  WB_o,
  output logic [31:0] MEMdata_o,
  output logic [31:0] ALUout_o,
  output logic [4:0]  RDaddr_o,
  output logic        err_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic access, illegal, ack;
  logic [1:0] hold_wb;
  logic [31:0] hold_alu;
  logic [4:0] hold_rd;
  assign access = (MEMR_i ^ MEMW_i) && ALUout_i[1:0] == 2'b00;
  assign illegal = (MEMR_i && MEMW_i) || ((MEMR_i || MEMW_i) && ALUout_i[1:0] != 2'b00);
  // an ack only counts while a request is actually outstanding
  assign ack = dmem_ack_i && dmem_req_o;
  always_comb begin
    state_d = state_q == IDLE ? (access ? BUSY : IDLE) : (ack ? IDLE : BUSY);
    stall_o = !rst_i && (state_q == IDLE ? access : !ack);
  end
  always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_req_o <= 1'b0;
      dmem_we_o <= 1'b0;
      dmem_addr_o <= '0;
      dmem_wdata_o <= '0;
      WB_o <= '0;
      MEMdata_o <= '0;
      ALUout_o <= '0;
      RDaddr_o <= '0;
      err_o <= 1'b0;
      hold_wb <= '0;
      hold_alu <= '0;
      hold_rd <= '0;
    end else if (state_q == IDLE) begin
      err_o <= illegal;
      ALUout_o <= ALUout_i;
      RDaddr_o <= RDaddr_i;
      WB_o <= (access || illegal) ? 2'b00 : WB_i;
      if (access) begin
        dmem_req_o <= 1'b1;
        dmem_we_o <= MEMW_i;
        dmem_addr_o <= ALUout_i;
        dmem_wdata_o <= RS2_i;
        hold_wb <= WB_i;
        hold_alu <= ALUout_i;
        hold_rd <= RDaddr_i;
      end
    end else begin
      err_o <= 1'b0;
      WB_o <= ack ? hold_wb : 2'b00;
      if (ack) begin
        dmem_req_o <= 1'b0;
        ALUout_o <= hold_alu;
        RDaddr_o <= hold_rd;
        if (!dmem_we_o) MEMdata_o <= dmem_rdata_i;
      end
    end
  end
endmodule
